// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO (w_clk domain): accepts pushes, drives the RAM
// write port, publishes a Gray write pointer and derives full/level/overflow from the synced read pointer.
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH   = 10,
   parameter int SYNC_STAGES  = 2,
   parameter int AFULL_THRESH = 1020
) (
   input  logic                  w_clk,
   input  logic                  rst_n,
   input  logic                  wr_req,
   output logic                  ram_w_en,
   output logic [ADDR_WIDTH-1:0] ram_w_addr,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gBadSync
         $error("fifo_wr_ctrl: SYNC_STAGES must be in 2..4");
      end
   endgenerate

   logic [ADDR_WIDTH:0] r_wr_ptr_bin;
   logic [ADDR_WIDTH:0] r_wr_ptr_gray;
   logic [ADDR_WIDTH:0] r_sync [SYNC_STAGES];
   logic                r_full;
   logic                r_overflow;

   logic                w_accept;
   logic [ADDR_WIDTH:0] w_wr_bin_next;
   logic [ADDR_WIDTH:0] w_wr_gray_next;
   logic [ADDR_WIDTH:0] w_rq;
   logic [ADDR_WIDTH:0] w_rd_bin_sync;
   logic [ADDR_WIDTH:0] w_full_match;

   // Reset also gates the write enable so nothing reaches the RAM while rst_n is low.
   assign w_accept       = wr_req & ~r_full & rst_n;
   assign w_wr_bin_next  = r_wr_ptr_bin + (ADDR_WIDTH+1)'(w_accept);
   assign w_wr_gray_next = w_wr_bin_next ^ (w_wr_bin_next >> 1);

   assign w_rq         = r_sync[SYNC_STAGES-1];
   assign w_full_match = {~w_rq[ADDR_WIDTH:ADDR_WIDTH-1], w_rq[ADDR_WIDTH-2:0]};

   always_comb begin
      w_rd_bin_sync = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         w_rd_bin_sync[i] = ^(w_rq >> i);
      end
   end

   // Binary pointer addresses the RAM; the Gray copy crosses domains straight from its flop.
   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr_bin  <= '0;
         r_wr_ptr_gray <= '0;
      end else begin
         r_wr_ptr_bin  <= w_wr_bin_next;
         r_wr_ptr_gray <= w_wr_gray_next;
      end
   end

   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= rd_ptr_gray_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   // Full is computed from the next pointer so it rises on the edge that takes the last slot.
   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_full <= (w_wr_gray_next == w_full_match);
         if (wr_req && r_full) begin
            r_overflow <= 1'b1;
         end else if (ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign ram_w_en    = w_accept;
   assign ram_w_addr  = r_wr_ptr_bin[ADDR_WIDTH-1:0];
   assign wr_ptr_gray = r_wr_ptr_gray;
   assign full        = r_full;
   assign overflow    = r_overflow;
   assign wr_level    = r_wr_ptr_bin - w_rd_bin_sync;
   assign almost_full = (wr_level >= AFULL_LVL);

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at ADDR_WIDTH=4, SYNC_STAGES=2, AFULL_THRESH=12.
module tb_fifo_wr_ctrl;

   logic       w_clk;
   logic       rst_n;
   logic       wr_req;
   logic       ram_w_en;
   logic [3:0] ram_w_addr;
   logic [4:0] wr_ptr_gray;
   logic [4:0] rd_ptr_gray_async;
   logic       full;
   logic       almost_full;
   logic [4:0] wr_level;
   logic       overflow;
   logic       ovf_clr;

   int assertCount = 0;
   int failCount   = 0;

   fifo_wr_ctrl #(
      .ADDR_WIDTH  (4),
      .SYNC_STAGES (2),
      .AFULL_THRESH(12)
   ) dut (
      .w_clk            (w_clk),
      .rst_n            (rst_n),
      .wr_req           (wr_req),
      .ram_w_en         (ram_w_en),
      .ram_w_addr       (ram_w_addr),
      .wr_ptr_gray      (wr_ptr_gray),
      .rd_ptr_gray_async(rd_ptr_gray_async),
      .full             (full),
      .almost_full      (almost_full),
      .wr_level         (wr_level),
      .overflow         (overflow),
      .ovf_clr          (ovf_clr)
   );

   initial begin
      w_clk = 1'b0;
      forever #5 w_clk = ~w_clk;
   end

   // Watchdog so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [4:0] toGray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic clr, input logic [4:0] rdGray);
      wr_req            = req;
      ovf_clr           = clr;
      rd_ptr_gray_async = rdGray;
      #1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_wen"},   32'(ram_w_en),    0);
      checkOutput({tag, "_addr"},  32'(ram_w_addr),  0);
      checkOutput({tag, "_gray"},  32'(wr_ptr_gray), 0);
      checkOutput({tag, "_full"},  32'(full),        0);
      checkOutput({tag, "_afull"}, 32'(almost_full), 0);
      checkOutput({tag, "_level"}, 32'(wr_level),    0);
      checkOutput({tag, "_ovf"},   32'(overflow),    0);
   endtask

   initial begin
      logic [4:0] b;
      logic [4:0] prevGray;

      // Reset with a request pending: nothing may be written
      rst_n             = 1'b0;
      wr_req            = 1'b1;
      ovf_clr           = 1'b0;
      rd_ptr_gray_async = 5'b0;
      #3;
      checkResetState("rst");
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 5'b0);
      checkResetState("postRst");

      // Fill sixteen entries with the read pointer parked at zero
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b0, 5'b0);
         checkOutput($sformatf("fill%0d_addr", i), 32'(ram_w_addr), i);
         checkOutput($sformatf("fill%0d_wen", i), 32'(ram_w_en), 1);
         checkOutput($sformatf("fill%0d_level", i), 32'(wr_level), i);
         checkOutput($sformatf("fill%0d_afull", i), 32'(almost_full), (i >= 12) ? 1 : 0);
         checkOutput($sformatf("fill%0d_full", i), 32'(full), 0);
         tick();
      end
      checkOutput("filled_full",  32'(full),        1);
      checkOutput("filled_level", 32'(wr_level),    16);
      checkOutput("filled_gray",  32'(wr_ptr_gray), 32'h18);
      checkOutput("filled_afull", 32'(almost_full), 1);
      checkOutput("filled_ovf",   32'(overflow),    0);

      // Seventeenth push is refused and flags overflow
      applyStimulus(1'b1, 1'b0, 5'b0);
      checkOutput("push17_wen", 32'(ram_w_en), 0);
      tick();
      checkOutput("push17_ovf",   32'(overflow),    1);
      checkOutput("push17_level", 32'(wr_level),    16);
      checkOutput("push17_gray",  32'(wr_ptr_gray), 32'h18);
      checkOutput("push17_addr",  32'(ram_w_addr),  0);

      // Overflow clear: set wins when coincident, clear alone takes effect
      applyStimulus(1'b1, 1'b1, 5'b0);
      tick();
      checkOutput("ovfSetWins", 32'(overflow), 1);
      applyStimulus(1'b0, 1'b1, 5'b0);
      tick();
      checkOutput("ovfCleared", 32'(overflow), 0);
      checkOutput("ovfClr_full", 32'(full), 1);

      // Drain release: read pointer advances to 1
      applyStimulus(1'b0, 1'b0, 5'b00001);
      tick();
      checkOutput("drain1_full",  32'(full),     1);
      checkOutput("drain1_level", 32'(wr_level), 16);
      tick();
      checkOutput("drain2_full",  32'(full),     1);
      checkOutput("drain2_level", 32'(wr_level), 15);
      tick();
      checkOutput("drain3_full",  32'(full),     0);
      checkOutput("drain3_level", 32'(wr_level), 15);
      applyStimulus(1'b1, 1'b0, 5'b00001);
      checkOutput("drainPush_wen",  32'(ram_w_en),   1);
      checkOutput("drainPush_addr", 32'(ram_w_addr), 0);
      tick();
      checkOutput("drainPush_full",  32'(full),        1);
      checkOutput("drainPush_level", 32'(wr_level),    16);
      checkOutput("drainPush_gray",  32'(wr_ptr_gray), 32'h19);

      // Streaming wrap with the synchronised read pointer trailing by four
      applyStimulus(1'b0, 1'b0, 5'b0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, 5'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, toGray(5'd2));
      tick();
      applyStimulus(1'b0, 1'b0, toGray(5'd3));
      tick();
      checkOutput("prime_level", 32'(wr_level), 4);
      for (int k = 0; k < 40; k++) begin
         b = 5'(6 + k);
         applyStimulus(1'b1, 1'b0, toGray(b - 5'd2));
         checkOutput($sformatf("wrap%0d_level", k), 32'(wr_level), 4);
         checkOutput($sformatf("wrap%0d_addr", k), 32'(ram_w_addr), 32'(b[3:0]));
         checkOutput($sformatf("wrap%0d_wen", k), 32'(ram_w_en), 1);
         prevGray = wr_ptr_gray;
         tick();
         checkOutput($sformatf("wrap%0d_gray", k), 32'(wr_ptr_gray), 32'(toGray(b + 5'd1)));
         checkOutput($sformatf("wrap%0d_oneBit", k), $countones(wr_ptr_gray ^ prevGray), 1);
         checkOutput($sformatf("wrap%0d_full", k), 32'(full), 0);
         if (b == 5'd31) begin
            checkOutput("wrap_prevGray", 32'(prevGray), 32'h10);
            checkOutput("wrap_zeroGray", 32'(wr_ptr_gray), 0);
            checkOutput("wrap_zeroAddr", 32'(ram_w_addr), 0);
         end
      end
      checkOutput("wrap_finalLevel", 32'(wr_level), 4);

      // Mid-operation reset: takes effect without a clock edge
      applyStimulus(1'b0, 1'b0, 5'b0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 1'b0, 5'b0);
         tick();
      end
      checkOutput("pre_midRst_addr", 32'(ram_w_addr), 7);
      applyStimulus(1'b1, 1'b0, 5'b0);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetState("midRst");
      applyStimulus(1'b0, 1'b0, 5'b0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 5'b0);
      checkOutput("afterRst_wen",  32'(ram_w_en),   1);
      checkOutput("afterRst_addr", 32'(ram_w_addr), 0);
      tick();
      checkOutput("afterRst_gray", 32'(wr_ptr_gray), 1);
      checkOutput("afterRst_addr1", 32'(ram_w_addr), 1);
      applyStimulus(1'b0, 1'b0, 5'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the asynchronous FIFO, in the w_clk domain, directly upstream of the dual-clock RAM's write port. Accepts push requests and drives the RAM write enable and write address. Publishes a Gray-coded write pointer for the read domain. Synchronises the read domain's Gray pointer and produces full, almost-full, fill level and a sticky overflow flag.

Parameters:
ADDR_WIDTH, 10, RAM address width; FIFO depth DEPTH = 2^ADDR_WIDTH
SYNC_STAGES, 2, flops in the rd-pointer synchroniser chain (legal range 2..4)
AFULL_THRESH, 1020, almost_full asserts when wr_level >= this value (1..DEPTH)

Ports:
w_clk  input  1  write-domain clock
rst_n  input  1  asynchronous, active-low reset
wr_req  input  1  push request from upstream; RAM data_in is driven by upstream in the same cycle
ram_w_en  output  1  RAM write enable
ram_w_addr  output  ADDR_WIDTH  RAM write address
wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchroniser
rd_ptr_gray_async  input  ADDR_WIDTH+1  Gray read pointer from the r_clk domain (asynchronous)
full  output  1  FIFO full, registered
almost_full  output  1  wr_level >= AFULL_THRESH
wr_level  output  ADDR_WIDTH+1  conservative fill count, 0..DEPTH
overflow  output  1  sticky: push attempted while full
ovf_clr  input  1  clears overflow

Behaviour:
- Reset (async, rst_n low): wr_ptr_bin=0, wr_ptr_gray=0, all sync flops=0, full=0, overflow=0. Hence ram_w_en=0, ram_w_addr=0, wr_level=0, almost_full=0.
- Reset is honoured mid-operation: all state returns to these values immediately, with no wait for a clock edge.
- Accept rule: accept = wr_req & ~full.
  - ram_w_en = accept, combinational.
  - ram_w_addr = wr_ptr_bin[ADDR_WIDTH-1:0], combinational from a register.
  - The RAM captures data on the same w_clk edge.
- Pointer: wr_ptr_bin is ADDR_WIDTH+1 bits.
  - wr_bin_next = wr_ptr_bin + accept, modulo 2^(ADDR_WIDTH+1); wraps naturally.
  - wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1).
  - Both pointers are registered on each w_clk edge.
  - wr_ptr_gray is driven straight from a flop, with no combinational logic on the crossing path.
- Synchroniser: rd_ptr_gray_async passes through a SYNC_STAGES-deep flop chain; rq = last stage.
  - rd_bin_sync = Gray-to-binary of rq (combinational XOR prefix).
- Full: full <= (wr_gray_next == {~rq[A:A-1], rq[A-2:0]}), where A = ADDR_WIDTH.
  - Registered from next-state, so full is set on the same edge that accepts the DEPTH-th entry.
  - Deassertion is pessimistic: full clears SYNC_STAGES+1 w_clk edges after the read pointer changes.
- Level: wr_level = wr_ptr_bin - rd_bin_sync, modulo 2^(A+1), combinational from registers. It never exceeds DEPTH.
  - almost_full = (wr_level >= AFULL_THRESH), combinational.
- Overflow: set on any edge where wr_req & full. Cleared by ovf_clr. When set and clear coincide, set wins.
- Push while full: no RAM write, pointer unchanged, overflow set.
- Push on the cycle full deasserts: accepted.
- No read-side logic lives in this block. Empty detection belongs to the read controller.

Test Plan:
(Bench uses ADDR_WIDTH=4, DEPTH=16, AFULL_THRESH=12, SYNC_STAGES=2.)
1. Reset check: rst_n low, then wr_req=1 -> ram_w_en=0 while rst_n low. After release: full=0, wr_level=0, wr_ptr_gray=0, overflow=0.
2. Fill, rd_ptr_gray_async held at 0: 16 consecutive pushes.
   - ram_w_addr steps 0..15.
   - almost_full asserts once wr_level=12.
   - full rises on the edge accepting push 16; wr_level=16, wr_ptr_gray=5'b11000.
   - 17th request gives ram_w_en=0 and overflow=1.
3. Drain release: from full, set rd_ptr_gray_async=5'b00001 (bin 1).
   - full stays 1 for 2 edges and clears after the 3rd edge; wr_level=15.
   - A push on that cycle is accepted at ram_w_addr=0.
4. Wrap: a long streaming test with the read pointer tracking the write pointer at lag 4.
   - wr_ptr_bin wraps 31->0 and wr_ptr_gray 5'b10000->5'b00000.
   - Exactly one bit of wr_ptr_gray changes per accept.
   - full never asserts and wr_level stays at 4.
5. Overflow clear: ovf_clr and wr_req both asserted while full -> overflow remains 1. ovf_clr alone -> overflow=0 next edge.
6. Mid-operation reset: assert rst_n low after 7 pushes -> all outputs return to reset values asynchronously. The next push after release writes ram_w_addr=0.
